// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle 8-bit ALU: op codes, FSM state
// encodings and the iteration terminal count.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_t;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_GAP   = 4'd1,
        S_LOAD2 = 4'd2,
        S_LOAD3 = 4'd3,
        S_ADD   = 4'd4,
        S_SUB   = 4'd5,
        S_MUL   = 4'd6,
        S_DIV   = 4'd7,
        S_DONE  = 4'd8
    } state_t;

    // Last step index of the 8-step multiply/divide loops.
    localparam logic [2:0] ITER_LAST = 3'd7;

endpackage

// File: rtl/alu_counter3.sv
// 3-bit iteration counter for the multiply and divide loops.
// c3 flags the terminal count so the FSM can leave the loop after that step.
module alu_counter3
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    output logic [2:0] count,
    output logic       c3
);

    // Count register: clear has priority over enable.
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= 3'd0;
        end else if (clr) begin
            count <= 3'd0;
        end else if (en) begin
            count <= count + 3'd1;
        end
    end

    assign c3 = (count == ITER_LAST);

endmodule

// File: rtl/alu_top.sv
// Multi-cycle 8-bit ALU: add, sub, signed Booth multiply, unsigned 16/8
// restoring divide. Operands arrive one byte per cycle on inbus after start;
// the result is presented as {A,Q} on outbus and held until the next start.
module alu_top
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  inbus,
    input  logic [1:0]  op,
    input  logic        start,
    output logic        final_pulse,
    output logic [15:0] outbus,
    output logic [3:0]  state,
    output logic [7:0]  A,
    output logic [7:0]  Q,
    output logic [7:0]  M,
    output logic        ready,
    output logic        c3_debug,
    output logic        op_latched_debug
);

    state_t      state_q;
    state_t      state_d;
    op_t         op_q;
    logic        q_m1;

    logic [2:0]  cnt;
    logic        cnt_last;
    logic        cnt_clr;
    logic        cnt_en;

    // Shared add/sub unit, 9-bit operands so multiply keeps the true sign and
    // divide can compare the shifted 9-bit partial remainder against M.
    logic [8:0]  alu_x;
    logic [8:0]  alu_y;
    logic        alu_sub;
    logic [9:0]  alu_sum;
    logic        booth_act;
    logic [8:0]  booth_a9;
    logic        div_ge;

    alu_counter3 u_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (cnt),
        .c3    (cnt_last)
    );

    assign cnt_clr = (state_q == S_LOAD2) || (state_q == S_LOAD3);
    assign cnt_en  = (state_q == S_MUL) || (state_q == S_DIV);

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    // NOTE: default assignment first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_GAP;
            S_GAP:   state_d = S_LOAD2;
            S_LOAD2: begin
                case (op_q)
                    OP_ADD:  state_d = S_ADD;
                    OP_SUB:  state_d = S_SUB;
                    OP_MUL:  state_d = S_MUL;
                    default: state_d = S_LOAD3;
                endcase
            end
            // Divide overflow (quotient would not fit, or M==0) skips the loop.
            S_LOAD3: state_d = (A >= inbus) ? S_DONE : S_DIV;
            S_ADD,
            S_SUB:   state_d = S_DONE;
            S_MUL,
            S_DIV:   if (cnt_last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs, all decoded from the current state.
    always_comb begin
        final_pulse      = (state_q == S_DONE);
        ready            = (state_q == S_IDLE);
        op_latched_debug = (state_q != S_IDLE);
        state            = state_q;
    end

    // Operand selection for the shared add/sub unit.
    always_comb begin
        alu_x   = {1'b0, A};
        alu_y   = {1'b0, M};
        alu_sub = 1'b0;
        case (state_q)
            S_SUB: alu_sub = 1'b1;
            S_MUL: begin
                alu_x   = {A[7], A};
                alu_y   = {M[7], M};
                alu_sub = Q[0] & ~q_m1;
            end
            S_DIV: begin
                alu_x   = {A, Q[7]};
                alu_sub = 1'b1;
            end
            default: ;
        endcase
    end

    // Bit 9 of a subtraction is the no-borrow flag, i.e. alu_x >= alu_y.
    assign alu_sum   = {1'b0, alu_x} + {1'b0, (alu_sub ? ~alu_y : alu_y)} + {9'd0, alu_sub};
    assign booth_act = Q[0] ^ q_m1;
    assign booth_a9  = booth_act ? alu_sum[8:0] : {A[7], A};
    assign div_ge    = alu_sum[9];

    // Datapath registers: operand loading, arithmetic steps and result hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            A    <= 8'd0;
            Q    <= 8'd0;
            M    <= 8'd0;
            q_m1 <= 1'b0;
            op_q <= OP_ADD;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q <= op_t'(op);
                        if (op == OP_DIV) A <= inbus;
                        else              M <= inbus;
                    end
                end
                S_LOAD2: begin
                    case (op_q)
                        OP_ADD,
                        OP_SUB: begin
                            A <= inbus;
                            Q <= 8'd0;
                        end
                        OP_MUL: begin
                            Q    <= inbus;
                            A    <= 8'd0;
                            q_m1 <= 1'b0;
                        end
                        default: Q <= inbus;
                    endcase
                end
                S_LOAD3: begin
                    M <= inbus;
                    if (A >= inbus) begin
                        A <= 8'hFF;
                        Q <= 8'hFF;
                    end
                end
                S_ADD,
                S_SUB: A <= alu_sum[7:0];
                S_MUL: begin
                    // Arithmetic right shift of {A,Q,Q-1} using the 9-bit sign.
                    A    <= booth_a9[8:1];
                    Q    <= {booth_a9[0], Q[7:1]};
                    q_m1 <= Q[0];
                end
                S_DIV: begin
                    if (div_ge) begin
                        A <= alu_sum[7:0];
                        Q <= {Q[6:0], 1'b1};
                    end else begin
                        A <= {A[6:0], Q[7]};
                        Q <= {Q[6:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    assign outbus   = {A, Q};
    assign c3_debug = cnt_last;

endmodule

// File: tb/tb_alu_top.sv
// Self-checking bench for alu_top: directed cases plus randomized operations
// compared against an arithmetic reference model.
module tb_alu_top;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  inbus;
    logic [1:0]  op;
    logic        start;
    logic        final_pulse;
    logic [15:0] outbus;
    logic [3:0]  state;
    logic [7:0]  A, Q, M;
    logic        ready;
    logic        c3_debug;
    logic        op_latched_debug;

    int n_checks = 0;
    int n_fail   = 0;

    alu_top dut (
        .clk              (clk),
        .rst              (rst),
        .inbus            (inbus),
        .op               (op),
        .start            (start),
        .final_pulse      (final_pulse),
        .outbus           (outbus),
        .state            (state),
        .A                (A),
        .Q                (Q),
        .M                (M),
        .ready            (ready),
        .c3_debug         (c3_debug),
        .op_latched_debug (op_latched_debug)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: result and latency derived from plain arithmetic.
    function automatic void model(input logic [1:0] o, input logic [7:0] b0, b1, b2,
                                  output int lat, output logic [15:0] res);
        int          p;
        int unsigned dvd;
        int unsigned quo;
        int unsigned rem;
        case (o)
            2'd0: begin lat = 4; res = {8'(b1 + b0), 8'h00}; end
            2'd1: begin lat = 4; res = {8'(b1 - b0), 8'h00}; end
            2'd2: begin
                lat = 11;
                p   = int'($signed(b0)) * int'($signed(b1));
                res = p[15:0];
            end
            default: begin
                if (b0 >= b2) begin
                    lat = 4;
                    res = 16'hFFFF;
                end else begin
                    lat = 12;
                    dvd = {16'd0, b0, b1};
                    quo = dvd / {24'd0, b2};
                    rem = dvd % {24'd0, b2};
                    res = {rem[7:0], quo[7:0]};
                end
            end
        endcase
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [7:0] b0, b1, b2, input bit spur);
        int          lat_exp;
        logic [15:0] res_exp;
        int          edges;
        logic        seen;
        model(o, b0, b1, b2, lat_exp, res_exp);
        @(negedge clk);
        op    = o;
        start = 1'b1;
        inbus = b0;
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 40) begin
            @(posedge clk);
            edges++;
            #1;
            if (edges == 1) check("ready_busy", ready, 0);
            if (o == 2'd2 && edges == 9)  check("c3_low", c3_debug, 0);
            if (o == 2'd2 && edges == 10) check("c3_high", c3_debug, 1);
            seen  = final_pulse;
            // A start (with a different op) in LOAD2 must be ignored.
            start = spur && (edges == 2);
            op    = (spur && edges == 2) ? ~o : o;
            inbus = (edges == 2) ? b1 : (edges == 3) ? b2 : 8'($urandom);
        end
        start = 1'b0;
        check("final_seen", seen, 1);
        check("latency", edges, lat_exp);
        check("result", outbus, res_exp);
        check("state_done", state, 8);
        check("op_latched", op_latched_debug, 1);
        @(posedge clk);
        #1;
        check("final_drop", final_pulse, 0);
        check("ready_idle", ready, 1);
        check("state_idle", state, 0);
        check("op_latched_clr", op_latched_debug, 0);
        repeat (2) begin
            @(posedge clk);
            #1;
            inbus = 8'($urandom);
        end
        check("outbus_hold", outbus, res_exp);
    endtask

    initial begin
        logic [1:0] ro;
        logic [7:0] r0, r1, r2;
        bit         rs;

        rst   = 1'b0;
        start = 1'b0;
        op    = 2'd0;
        inbus = 8'd0;
        #12;
        check("rst_state", state, 0);
        check("rst_outbus", outbus, 0);
        check("rst_ready", ready, 1);
        check("rst_final", final_pulse, 0);
        check("rst_M", M, 0);
        check("rst_oplat", op_latched_debug, 0);
        @(negedge clk);
        rst = 1'b1;

        run_op(2'd0, 8'd20, 8'd10, 8'd0, 1'b0);
        run_op(2'd1, 8'd10, 8'd30, 8'd0, 1'b0);
        run_op(2'd1, 8'd30, 8'd10, 8'd0, 1'b1);
        run_op(2'd2, 8'd5, 8'd4, 8'd0, 1'b0);
        run_op(2'd2, 8'hFD, 8'd7, 8'd0, 1'b0);
        run_op(2'd2, 8'h80, 8'h80, 8'd0, 1'b1);
        run_op(2'd3, 8'h03, 8'hE8, 8'd12, 1'b0);
        run_op(2'd3, 8'h10, 8'h00, 8'h08, 1'b0);
        run_op(2'd3, 8'h00, 8'h05, 8'h00, 1'b0);
        run_op(2'd3, 8'hFE, 8'hFF, 8'hFF, 1'b1);

        repeat (40) begin
            ro = 2'($urandom_range(0, 3));
            r0 = 8'($urandom);
            r1 = 8'($urandom);
            r2 = 8'($urandom);
            rs = 1'($urandom_range(0, 1));
            if (ro == 2'd3 && r2 != 8'd0 && $urandom_range(0, 3) != 0)
                r0 = 8'($urandom_range(0, int'(r2) - 1));
            run_op(ro, r0, r1, r2, rs);
        end

        // Reset in the middle of a multiply.
        @(negedge clk);
        op    = 2'd2;
        start = 1'b1;
        inbus = 8'h7F;
        @(negedge clk);
        start = 1'b0;
        inbus = 8'h03;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_state", state, 0);
        check("midrst_outbus", outbus, 0);
        check("midrst_ready", ready, 1);
        check("midrst_final", final_pulse, 0);
        @(negedge clk);
        rst = 1'b1;
        run_op(2'd0, 8'd100, 8'd200, 8'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
